i2c_reg_slave: RTL and testbench

I2C responder that terminates the register-write/read transactions issued by the team's I2C configuration master: device address, register address, then data bytes. Decodes START/STOP, matches a 7-bit device address, and converts each transferred byte into a one-cycle strobe on a simple register-access bus. Used to model and bench the configuration path, and as an on-chip config target. No clock stretching, so SCL is never driven.

---
 rtl/i2c_reg_slave_if.sv | 10 +
 rtl/i2c_reg_slave.sv | 151 +++++++++++++++
 tb/tb_i2c_reg_slave.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_reg_slave_if.sv
// i2c_reg_slave_if: register-access bus between the I2C responder and its register file.
interface i2c_reg_slave_if;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  modport master(output reg_wr, reg_rd, reg_addr, reg_wdata, input reg_rdata);
  modport slave(input reg_wr, reg_rd, reg_addr, reg_wdata, output reg_rdata);
endinterface

// File: rtl/i2c_reg_slave.sv
// i2c_reg_slave: I2C responder turning device/register/data byte transfers into register bus strobes.
module i2c_reg_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h39
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           scl_pad_i,
  input  logic           sda_pad_i,
  output logic           sda_pad_o,
  output logic           sda_padoen_o,
  output logic           busy,
  i2c_reg_slave_if.master bus
);
  typedef enum logic [3:0] {IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_MACK, IGNORE} state_t;
  state_t     state, state_n;
  logic [1:0] scl_s, sda_s;
  logic       scl_d, sda_d;
  logic [2:0] vld;
  logic [2:0] cnt, cnt_n;
  logic [7:0] sh, sh_n, addr, addr_n, wdata, wdata_n;
  logic       oe, oe_n, wr, wr_n, rd, rd_n, ld, bsy, bsy_n, rw, rw_n;
  logic       scl, sda, rise, fall, start, stop, hit;
  // vld masks edge detection until the history holds real bus values, so a reset mid-frame cannot fake a START
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
      vld   <= '0;
    end else begin
      scl_s <= {scl_s[0], scl_pad_i};
      sda_s <= {sda_s[0], sda_pad_i};
      scl_d <= scl_s[1];
      sda_d <= sda_s[1];
      vld   <= {vld[1:0], 1'b1};
    end
  end
  assign scl   = scl_s[1];
  assign sda   = sda_s[1];
  assign rise  = vld[2] & scl & ~scl_d;
  assign fall  = vld[2] & ~scl & scl_d;
  assign start = vld[2] & scl & scl_d & sda_d & ~sda;
  assign stop  = vld[2] & scl & scl_d & ~sda_d & sda;
  assign hit   = sh[6:0] == SLAVE_ADDR;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
      addr  <= '0;
      wdata <= '0;
      oe    <= 1'b1;
      wr    <= 1'b0;
      rd    <= 1'b0;
      ld    <= 1'b0;
      bsy   <= 1'b0;
      rw    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sh    <= sh_n;
      addr  <= addr_n;
      wdata <= wdata_n;
      oe    <= oe_n;
      wr    <= wr_n;
      rd    <= rd_n;
      ld    <= rd;
      bsy   <= bsy_n;
      rw    <= rw_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    addr_n  = addr;
    wdata_n = wdata;
    oe_n    = oe;
    wr_n    = 1'b0;
    rd_n    = 1'b0;
    bsy_n   = bsy;
    rw_n    = rw;
    if (start) begin
      state_n = DEV_ADDR;
      cnt_n   = '0;
      oe_n    = 1'b1;
    end else if (stop) begin
      state_n = IDLE;
      bsy_n   = 1'b0;
      oe_n    = 1'b1;
    end else begin
      case (state)
        DEV_ADDR, REG_ADDR, WR_DATA: if (rise) begin
          sh_n  = {sh[6:0], sda};
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd7) begin
            if (state == DEV_ADDR) begin
              state_n = hit ? DEV_ACK : IGNORE;
              bsy_n   = bsy | hit;
              rw_n    = sda;
            end else if (state == REG_ADDR) begin
              addr_n  = sh_n;
              state_n = REG_ACK;
            end else begin
              wdata_n = sh_n;
              wr_n    = 1'b1;
              state_n = WR_ACK;
            end
          end
        end
        // oe doubles as the ACK phase flag: first fall drives low, second fall releases and moves on
        DEV_ACK, REG_ACK, WR_ACK: if (fall) begin
          oe_n = ~oe;
          if (!oe) begin
            state_n = state == DEV_ACK ? (rw ? RD_DATA : REG_ADDR) : WR_DATA;
            rd_n    = state == DEV_ACK && rw;
            addr_n  = state == WR_ACK ? addr + 8'd1 : addr;
          end
        end
        RD_DATA: if (ld) begin
          sh_n = bus.reg_rdata;
          oe_n = bus.reg_rdata[7];
        end else if (fall) begin
          cnt_n   = cnt + 3'd1;
          sh_n    = {sh[6:0], 1'b0};
          oe_n    = cnt == 3'd7 ? 1'b1 : sh[6];
          state_n = cnt == 3'd7 ? RD_MACK : RD_DATA;
        end
        // the master's ACK is taken on the rise, but the next byte only starts on the following fall
        RD_MACK: if (rise) begin
          state_n = sda ? IGNORE : RD_MACK;
          addr_n  = sda ? addr : addr + 8'd1;
          cnt_n   = {2'b00, ~sda};
        end else if (fall && cnt[0]) begin
          state_n = RD_DATA;
          rd_n    = 1'b1;
          cnt_n   = '0;
        end
        default: ;
      endcase
    end
  end
  assign sda_pad_o     = 1'b0;
  assign sda_padoen_o  = oe;
  assign busy          = bsy;
  assign bus.reg_wr    = wr;
  assign bus.reg_rd    = rd;
  assign bus.reg_addr  = addr;
  assign bus.reg_wdata = wdata;
endmodule

// File: tb/tb_i2c_reg_slave.sv
// tb_i2c_reg_slave: bit-banged I2C master plus register-file responder; strobes are checked
// against a pointer/memory model through a scoreboard queue.
module tb_i2c_reg_slave;
  localparam int Q = 10;
  typedef struct {
    bit         rd;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;
  logic clk = 1'b0;
  logic rst, scl, sda_m, sda, sda_pad_o, sda_padoen_o, busy;
  logic [7:0] ptr;
  logic [7:0] ref_mem [256];
  logic [7:0] rf [256];
  logic [7:0] dbytes [$];
  ev_t        sbq [$];
  ev_t        e;
  bit         watch, rel_bad;
  int         vectors, miscompares;
  i2c_reg_slave_if bus();
  i2c_reg_slave dut (
    .clk(clk), .rst(rst), .scl_pad_i(scl), .sda_pad_i(sda),
    .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o), .busy(busy), .bus(bus)
  );
  assign sda = sda_m & (sda_padoen_o | sda_pad_o);
  always #5 clk = ~clk;
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
  // register-file responder and scoreboard monitor
  always @(negedge clk) begin
    if (bus.reg_wr || bus.reg_rd) begin
      vectors++;
      if (sbq.size() == 0) begin
        miscompares++;
        $display("FAIL strobe: unexpected rd=%0b wr=%0b addr=%02h wdata=%02h", bus.reg_rd, bus.reg_wr, bus.reg_addr, bus.reg_wdata);
      end else begin
        e = sbq.pop_front();
        if (bus.reg_wr == bus.reg_rd || e.rd != bus.reg_rd || e.addr != bus.reg_addr || (!e.rd && e.data != bus.reg_wdata)) begin
          miscompares++;
          $display("FAIL strobe: got rd=%0b wr=%0b addr=%02h wdata=%02h, required rd=%0b addr=%02h wdata=%02h",
                   bus.reg_rd, bus.reg_wr, bus.reg_addr, bus.reg_wdata, e.rd, e.addr, e.data);
        end
      end
      if (bus.reg_wr) rf[bus.reg_addr] = bus.reg_wdata;
      if (bus.reg_rd) bus.reg_rdata = rf[bus.reg_addr];
    end
    if (watch && !sda_padoen_o) rel_bad = 1'b1;
  end
  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h required %02h", name, act, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_start();
    sda_m = 1'b1; tick(Q);
    scl = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl = 1'b0; tick(Q);
  endtask
  task automatic do_stop();
    sda_m = 1'b0; tick(Q);
    scl = 1'b1; tick(Q);
    sda_m = 1'b1; tick(2 * Q);
  endtask
  task automatic wbit(bit b, bit g);
    sda_m = b;
    if (g) begin
      tick(3); sda_m = ~b; tick(1); sda_m = b; tick(Q - 4);
    end else tick(Q);
    scl = 1'b1; tick(2 * Q);
    scl = 1'b0; tick(Q);
  endtask
  task automatic rbit(output bit b);
    sda_m = 1'b1; tick(Q);
    scl = 1'b1; tick(Q);
    b = sda; tick(Q);
    scl = 1'b0; tick(Q);
  endtask
  task automatic wbyte(logic [7:0] v, bit g, output bit ack);
    for (int i = 7; i >= 0; i--) wbit(v[i], g && i == 4);
    rbit(ack);
  endtask
  task automatic rbyte(output logic [7:0] v, input bit nack);
    bit b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      v[i] = b;
    end
    wbit(nack, 1'b0);
  endtask
  task automatic write_frame(logic [7:0] dev, logic [7:0] ra, bit g);
    bit ack, m;
    m = dev[7:1] == 7'h39;
    watch = !m;
    rel_bad = 1'b0;
    do_start();
    wbyte(dev, 1'b0, ack);
    chk("dev ack", 8'(ack), 8'(!m));
    chk("busy after dev", 8'(busy), 8'(m));
    wbyte(ra, 1'b0, ack);
    chk("reg ack", 8'(ack), 8'(!m));
    if (m) ptr = ra;
    foreach (dbytes[i]) begin
      if (m) begin
        sbq.push_back('{rd: 1'b0, addr: ptr, data: dbytes[i]});
        ref_mem[ptr] = dbytes[i];
      end
      wbyte(dbytes[i], g && i == 0, ack);
      chk("data ack", 8'(ack), 8'(!m));
      if (m) ptr = ptr + 8'd1;
    end
    do_stop();
    chk("busy after stop", 8'(busy), 8'h00);
    if (!m) chk("sda released", 8'(rel_bad), 8'h00);
    watch = 1'b0;
  endtask
  task automatic read_frame(logic [7:0] ra, int n);
    bit ack;
    logic [7:0] v;
    do_start();
    wbyte(8'h72, 1'b0, ack);
    chk("rd dev w ack", 8'(ack), 8'h00);
    wbyte(ra, 1'b0, ack);
    chk("rd reg ack", 8'(ack), 8'h00);
    ptr = ra;
    do_start();
    sbq.push_back('{rd: 1'b1, addr: ptr, data: 8'h00});
    wbyte(8'h73, 1'b0, ack);
    chk("rd dev r ack", 8'(ack), 8'h00);
    chk("busy in read", 8'(busy), 8'h01);
    for (int i = 0; i < n; i++) begin
      if (i < n - 1) sbq.push_back('{rd: 1'b1, addr: ptr + 8'd1, data: 8'h00});
      rbyte(v, i == n - 1);
      chk("rd data", v, ref_mem[ptr]);
      if (i < n - 1) ptr = ptr + 8'd1;
    end
    chk("released after nack", 8'(sda_padoen_o), 8'h01);
    do_stop();
    chk("busy after rd stop", 8'(busy), 8'h00);
  endtask
  initial begin
    bit ack, b;
    int r, n;
    logic [7:0] dev, ra;
    rst = 1'b1; scl = 1'b1; sda_m = 1'b1; bus.reg_rdata = 8'h00;
    watch = 1'b0; rel_bad = 1'b0; ptr = 8'h00;
    for (int i = 0; i < 256; i++) begin
      ra = 8'($urandom);
      ref_mem[i] = ra;
      rf[i] = ra;
    end
    tick(3);
    chk("rst padoen", 8'(sda_padoen_o), 8'h01);
    chk("rst reg_wr", 8'(bus.reg_wr), 8'h00);
    chk("rst reg_rd", 8'(bus.reg_rd), 8'h00);
    chk("rst reg_addr", bus.reg_addr, 8'h00);
    chk("rst reg_wdata", bus.reg_wdata, 8'h00);
    chk("rst busy", 8'(busy), 8'h00);
    rst = 1'b0;
    tick(10);
    dbytes = '{8'h35};
    write_frame(8'h72, 8'h08, 1'b0);
    dbytes = '{8'hAA, 8'hBB, 8'hCC};
    write_frame(8'h72, 8'hFE, 1'b0);
    dbytes = '{8'h10};
    write_frame(8'h60, 8'h05, 1'b0);
    ref_mem[8'h2F] = 8'hA5; rf[8'h2F] = 8'hA5;
    ref_mem[8'h30] = 8'h3C; rf[8'h30] = 8'h3C;
    read_frame(8'h2F, 2);
    // STOP four bits into a data byte
    do_start();
    wbyte(8'h72, 1'b0, ack);
    chk("abort dev ack", 8'(ack), 8'h00);
    wbyte(8'h40, 1'b0, ack);
    chk("abort reg ack", 8'(ack), 8'h00);
    ptr = 8'h40;
    for (int i = 0; i < 4; i++) wbit(1'(i), 1'b0);
    do_stop();
    chk("abort busy", 8'(busy), 8'h00);
    chk("abort padoen", 8'(sda_padoen_o), 8'h01);
    // reset pulse while the responder drives a zero read bit
    ref_mem[8'h10] = 8'h00; rf[8'h10] = 8'h00;
    do_start();
    wbyte(8'h72, 1'b0, ack);
    wbyte(8'h10, 1'b0, ack);
    ptr = 8'h10;
    do_start();
    sbq.push_back('{rd: 1'b1, addr: ptr, data: 8'h00});
    wbyte(8'h73, 1'b0, ack);
    chk("mid-read ack", 8'(ack), 8'h00);
    for (int i = 0; i < 3; i++) rbit(b);
    chk("mid-read drive", 8'(sda_padoen_o), 8'h00);
    rst = 1'b1;
    #1;
    chk("rst async padoen", 8'(sda_padoen_o), 8'h01);
    chk("rst async busy", 8'(busy), 8'h00);
    chk("rst async addr", bus.reg_addr, 8'h00);
    tick(3);
    rst = 1'b0;
    ptr = 8'h00;
    do_stop();
    dbytes = '{8'h5A, 8'hC3};
    write_frame(8'h72, 8'h20, 1'b0);
    dbytes = '{8'h96, 8'h69};
    write_frame(8'h72, 8'h50, 1'b1);
    for (int k = 0; k < 8; k++) begin
      r = int'($urandom_range(0, 3));
      n = int'($urandom_range(1, 3));
      ra = 8'($urandom);
      dbytes.delete();
      for (int j = 0; j < n; j++) dbytes.push_back(8'($urandom));
      if (r == 0) begin
        dev = {7'($urandom), 1'b0};
        if (dev[7:1] == 7'h39) dev = 8'h50;
        write_frame(dev, ra, 1'b0);
      end else if (r == 3) read_frame(ra, n);
      else write_frame(8'h72, ra, 1'b0);
    end
    tick(20);
    chk("scoreboard drained", 8'(sbq.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
